// File: rtl/game_pkg.sv
// Shared definitions for the game countdown timer: state encoding and BCD digit constants.
package game_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   function automatic logic [DIGIT_W-1:0] clamp_bcd(input logic [DIGIT_W-1:0] digit);
      return (digit > BCD_MAX) ? BCD_MAX : digit;
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit: clear, saturating load, decrement with borrow to 9.
module bcd_down_digit
   import game_pkg::*;
(
   input  logic               ClockIn,
   input  logic               Reset,
   input  logic               Clear,
   input  logic               Load,
   input  logic [DIGIT_W-1:0] LoadValue,
   input  logic               Dec,
   output logic [DIGIT_W-1:0] Value,
   output logic [DIGIT_W-1:0] ValueNext,
   output logic               BorrowOut,
   output logic               Zero
);

   logic [DIGIT_W-1:0] value_reg;
   logic [DIGIT_W-1:0] value_next;

   assign Zero      = (value_reg == '0);
   assign BorrowOut = Dec && Zero;

   always_comb begin
      value_next = value_reg;
      if (Clear) begin
         value_next = '0;
      end else if (Load) begin
         value_next = clamp_bcd(LoadValue);
      end else if (Dec) begin
         value_next = Zero ? BCD_MAX : value_reg - 1'b1;
      end
   end

   always_ff @(posedge ClockIn) begin
      if (Reset) begin
         value_reg <= '0;
      end else begin
         value_reg <= value_next;
      end
   end

   assign Value     = value_reg;
   assign ValueNext = value_next;

endmodule

// File: rtl/game_timer.sv
// Two-digit BCD game countdown timer with pause, abort, expiry pulse and low-time warning.
module game_timer
   import game_pkg::*;
#(
   parameter int WARN_SECONDS = 10
) (
   input  logic               ClockIn,
   input  logic               Reset,
   input  logic               Tick,
   input  logic               Start,
   input  logic               Pause,
   input  logic               Abort,
   input  logic [DIGIT_W-1:0] StartTens,
   input  logic [DIGIT_W-1:0] StartOnes,
   output logic [DIGIT_W-1:0] TensCounterValue,
   output logic [DIGIT_W-1:0] OnesCounterValue,
   output logic [1:0]         State,
   output logic               TimeUp,
   output logic               Warning
);

   state_t state_reg, state_next;
   logic   time_up_reg, time_up_next;
   logic   warning_reg, warning_next;

   logic               digit_clear;
   logic               digit_load;
   logic               tick_dec;
   logic               ones_borrow;
   logic               ones_zero;
   logic               tens_zero;
   logic               unused_tens_borrow;
   logic [DIGIT_W-1:0] ones_value, ones_value_next;
   logic [DIGIT_W-1:0] tens_value, tens_value_next;
   logic [6:0]         remaining_next;
   logic               start_is_zero;

   bcd_down_digit u_ones (
      .ClockIn   (ClockIn),
      .Reset     (Reset),
      .Clear     (digit_clear),
      .Load      (digit_load),
      .LoadValue (StartOnes),
      .Dec       (tick_dec),
      .Value     (ones_value),
      .ValueNext (ones_value_next),
      .BorrowOut (ones_borrow),
      .Zero      (ones_zero)
   );

   // Tens never borrows: the FSM stops counting at 00, so its borrow-out has no consumer.
   bcd_down_digit u_tens (
      .ClockIn   (ClockIn),
      .Reset     (Reset),
      .Clear     (digit_clear),
      .Load      (digit_load),
      .LoadValue (StartTens),
      .Dec       (ones_borrow),
      .Value     (tens_value),
      .ValueNext (tens_value_next),
      .BorrowOut (unused_tens_borrow),
      .Zero      (tens_zero)
   );

   assign start_is_zero = (StartTens == '0) && (StartOnes == '0);

   always_comb begin
      state_next   = state_reg;
      time_up_next = 1'b0;
      digit_clear  = 1'b0;
      digit_load   = 1'b0;
      tick_dec     = 1'b0;
      if (Abort) begin
         digit_clear = 1'b1;
         state_next  = ST_IDLE;
      end else if (Start && (state_reg == ST_IDLE || state_reg == ST_EXPIRED)) begin
         digit_load = 1'b1;
         if (start_is_zero) begin
            state_next   = ST_EXPIRED;
            time_up_next = 1'b1;
         end else begin
            state_next = ST_RUNNING;
         end
      end else begin
         case (state_reg)
            ST_RUNNING: begin
               if (Pause) begin
                  state_next = ST_PAUSED;
               end else if (Tick && !(tens_zero && ones_zero)) begin
                  tick_dec = 1'b1;
                  if (tens_zero && ones_value == 4'd1) begin
                     state_next   = ST_EXPIRED;
                     time_up_next = 1'b1;
                  end
               end
            end
            ST_PAUSED: begin
               if (!Pause) begin
                  state_next = ST_RUNNING;
               end
            end
            default: ;
         endcase
      end
   end

   // Warning is derived from next-cycle values so it lines up with the registered digits.
   assign remaining_next = 7'(tens_value_next) * 7'd10 + 7'(ones_value_next);

   always_comb begin
      warning_next = ((state_next == ST_RUNNING) || (state_next == ST_PAUSED))
                     && (remaining_next <= 7'(WARN_SECONDS));
   end

   always_ff @(posedge ClockIn) begin
      if (Reset) begin
         state_reg   <= ST_IDLE;
         time_up_reg <= 1'b0;
         warning_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         time_up_reg <= time_up_next;
         warning_reg <= warning_next;
      end
   end

   assign State            = state_reg;
   assign TimeUp           = time_up_reg;
   assign Warning          = warning_reg;
   assign TensCounterValue = tens_value;
   assign OnesCounterValue = ones_value;

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: each driven cycle queues its expected outputs, checked after the edge.
module tb_game_timer;

   localparam int S_IDLE    = 0;
   localparam int S_RUNNING = 1;
   localparam int S_PAUSED  = 2;
   localparam int S_EXPIRED = 3;
   localparam int WARN      = 10;

   logic       ClockIn = 1'b0;
   logic       Reset   = 1'b0;
   logic       Tick    = 1'b0;
   logic       Start   = 1'b0;
   logic       Pause   = 1'b0;
   logic       Abort   = 1'b0;
   logic [3:0] StartTens = 4'd0;
   logic [3:0] StartOnes = 4'd0;
   logic [3:0] TensCounterValue;
   logic [3:0] OnesCounterValue;
   logic [1:0] State;
   logic       TimeUp;
   logic       Warning;

   int vectors    = 0;
   int miscompares = 0;

   typedef struct {
      string tag;
      int    st;
      int    val;
      int    tu;
      int    warn;
   } exp_t;

   exp_t exp_q[$];

   game_timer #(.WARN_SECONDS(WARN)) dut (
      .ClockIn          (ClockIn),
      .Reset            (Reset),
      .Tick             (Tick),
      .Start            (Start),
      .Pause            (Pause),
      .Abort            (Abort),
      .StartTens        (StartTens),
      .StartOnes        (StartOnes),
      .TensCounterValue (TensCounterValue),
      .OnesCounterValue (OnesCounterValue),
      .State            (State),
      .TimeUp           (TimeUp),
      .Warning          (Warning)
   );

   always #5 ClockIn = ~ClockIn;

   task automatic check_val(input string tag, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, want);
      end
   endtask

   // Drive one cycle of inputs, queue what the outputs must be after the edge, then check.
   task automatic step(input string tag, input logic rst, tk, stt, pa, ab,
                       input int tens, ones, es, ev, etu);
      exp_t e;
      exp_t got_e;
      @(negedge ClockIn);
      Reset     = rst;
      Tick      = tk;
      Start     = stt;
      Pause     = pa;
      Abort     = ab;
      StartTens = 4'(tens);
      StartOnes = 4'(ones);
      e.tag  = tag;
      e.st   = es;
      e.val  = ev;
      e.tu   = etu;
      e.warn = ((es == S_RUNNING || es == S_PAUSED) && ev <= WARN) ? 1 : 0;
      exp_q.push_back(e);
      @(posedge ClockIn);
      #1;
      if (exp_q.size() == 0) begin
         check_val({tag, "_queue"}, 0, 1);
      end else begin
         got_e = exp_q.pop_front();
         check_val({got_e.tag, "_state"}, int'(State), got_e.st);
         check_val({got_e.tag, "_tens"}, int'(TensCounterValue), got_e.val / 10);
         check_val({got_e.tag, "_ones"}, int'(OnesCounterValue), got_e.val % 10);
         check_val({got_e.tag, "_timeup"}, int'(TimeUp), got_e.tu);
         check_val({got_e.tag, "_warning"}, int'(Warning), got_e.warn);
         $display("cycle %s: state=%0d value=%0d%0d timeup=%0b warning=%0b",
                  got_e.tag, State, TensCounterValue, OnesCounterValue, TimeUp, Warning);
      end
   endtask

   initial begin
      // Reset overrides a coincident Start
      step("rst_start", 1, 0, 1, 0, 0, 3, 0, S_IDLE, 0, 0);
      step("idle", 0, 0, 0, 0, 0, 0, 0, S_IDLE, 0, 0);

      // Countdown from 30 to expiry
      step("load30", 0, 0, 1, 0, 0, 3, 0, S_RUNNING, 30, 0);
      for (int i = 1; i <= 30; i++) begin
         step("cnt30", 0, 1, 0, 0, 0, 0, 0,
              (i == 30) ? S_EXPIRED : S_RUNNING, 30 - i, (i == 30) ? 1 : 0);
      end
      step("exp_hold", 0, 0, 0, 0, 0, 0, 0, S_EXPIRED, 0, 0);
      step("exp_tick", 0, 1, 0, 0, 0, 0, 0, S_EXPIRED, 0, 0);

      // Pause with coincident tick, ticks while paused, resume
      step("load12", 0, 0, 1, 0, 0, 1, 2, S_RUNNING, 12, 0);
      step("pause_tick", 0, 1, 0, 1, 0, 0, 0, S_PAUSED, 12, 0);
      for (int i = 0; i < 5; i++) begin
         step("paused_tick", 0, 1, 0, 1, 0, 0, 0, S_PAUSED, 12, 0);
      end
      step("resume", 0, 0, 0, 0, 0, 0, 0, S_RUNNING, 12, 0);
      step("resume_tick", 0, 1, 0, 0, 0, 0, 0, S_RUNNING, 11, 0);
      step("abort12", 0, 0, 0, 0, 1, 0, 0, S_IDLE, 0, 0);

      // Warning threshold from 15 down
      step("load15", 0, 0, 1, 0, 0, 1, 5, S_RUNNING, 15, 0);
      for (int i = 1; i <= 15; i++) begin
         step("warn15", 0, 1, 0, 0, 0, 0, 0,
              (i == 15) ? S_EXPIRED : S_RUNNING, 15 - i, (i == 15) ? 1 : 0);
      end
      step("warn_exp", 0, 0, 0, 0, 0, 0, 0, S_EXPIRED, 0, 0);

      // Digit clamping and zero load
      step("loadF7", 0, 0, 1, 0, 0, 15, 7, S_RUNNING, 97, 0);
      step("abortF7", 0, 0, 0, 0, 1, 0, 0, S_IDLE, 0, 0);
      step("load3C", 0, 0, 1, 0, 0, 3, 12, S_RUNNING, 39, 0);
      step("ignore_start", 0, 0, 1, 0, 0, 5, 5, S_RUNNING, 39, 0);
      step("abort3C", 0, 0, 0, 0, 1, 0, 0, S_IDLE, 0, 0);
      step("load00", 0, 0, 1, 0, 0, 0, 0, S_EXPIRED, 0, 1);
      step("z_hold", 0, 0, 0, 0, 0, 0, 0, S_EXPIRED, 0, 0);
      step("z_tick", 0, 1, 0, 0, 0, 0, 0, S_EXPIRED, 0, 0);

      // Abort beats a coincident Start
      step("load08", 0, 0, 1, 0, 0, 0, 8, S_EXPIRED == 3 ? S_RUNNING : S_IDLE, 8, 0);
      step("abort_start", 0, 0, 1, 0, 1, 4, 4, S_IDLE, 0, 0);

      // Reset mid-count at 05, then no expiry pulse afterwards
      step("load08b", 0, 0, 1, 0, 0, 0, 8, S_RUNNING, 8, 0);
      for (int i = 1; i <= 3; i++) begin
         step("cnt08", 0, 1, 0, 0, 0, 0, 0, S_RUNNING, 8 - i, 0);
      end
      step("rst_at05", 1, 1, 0, 0, 0, 0, 0, S_IDLE, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step("post_rst", 0, 1, 0, 0, 0, 0, 0, S_IDLE, 0, 0);
      end

      // Pause is inert in IDLE; Start with Pause high runs then pauses
      step("idle_pause", 0, 0, 0, 1, 0, 0, 0, S_IDLE, 0, 0);
      step("start_pause", 0, 1, 1, 1, 0, 2, 0, S_RUNNING, 20, 0);
      step("then_paused", 0, 1, 0, 1, 0, 0, 0, S_PAUSED, 20, 0);
      step("final_abort", 0, 0, 0, 0, 1, 0, 0, S_IDLE, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
- REQ-001 The block SHALL have parameter WARN_SECONDS, default 10, meaning that Warning asserts at or below this remaining time (0..99).
- REQ-002 The block SHALL have port ClockIn, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-003 The block SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
- REQ-004 The block SHALL have port Tick, input, 1 bit: one-cycle 1 Hz enable pulse from the upstream rate divider.
- REQ-005 The block SHALL have port Start, input, 1 bit: one-cycle request to load the start time and begin the countdown.
- REQ-006 The block SHALL have port Pause, input, 1 bit: level; high freezes the countdown.
- REQ-007 The block SHALL have port Abort, input, 1 bit: one-cycle request to return to IDLE.
- REQ-008 The block SHALL have ports StartTens and StartOnes, input, 4 bits each: BCD start-time digits.
- REQ-009 The block SHALL have ports TensCounterValue and OnesCounterValue, output, 4 bits each: remaining-time BCD digits, registered, feeding the hex decoders.
- REQ-010 The block SHALL have port State, output, 2 bits: current FSM state encoding.
- REQ-011 The block SHALL have port TimeUp, output, 1 bit: one-cycle pulse on expiry.
- REQ-012 The block SHALL have port Warning, output, 1 bit: level; low time remaining.

Function
- REQ-013 The FSM SHALL have four states: IDLE=0, RUNNING=1, PAUSED=2, EXPIRED=3.
- REQ-014 Input priority per edge SHALL be Abort > Start > Pause > Tick.
- REQ-015 Abort in any state SHALL go to IDLE with both digits cleared to 0 on the next edge.
- REQ-016 Start in IDLE or EXPIRED SHALL load StartTens/StartOnes into the digits and enter RUNNING; any digit >9 SHALL load as 9.
- REQ-017 Start in RUNNING or PAUSED SHALL be ignored.
- REQ-018 A Start that loads 00 SHALL enter EXPIRED directly and pulse TimeUp on the following cycle.
- REQ-019 RUNNING with Pause=1 SHALL enter PAUSED; a coincident Tick SHALL be discarded.
- REQ-020 PAUSED with Pause=0 SHALL return to RUNNING; Ticks in PAUSED, IDLE and EXPIRED SHALL be ignored.
- REQ-021 On a Tick in RUNNING, if ones>0, ones SHALL decrement.
- REQ-022 On a Tick in RUNNING with ones=0 and tens>0, ones SHALL go to 9 and tens SHALL decrement (borrow).
- REQ-023 When a Tick in RUNNING takes the value from 01 to 00, the state SHALL become EXPIRED and TimeUp SHALL be high for exactly one cycle, the cycle after that edge.
- REQ-024 The digits SHALL never wrap below 00.
- REQ-025 The digits SHALL hold in EXPIRED until Start or Abort.
- REQ-026 Warning SHALL be 1 iff the state is RUNNING or PAUSED and (tens*10 + ones) <= WARN_SECONDS; it SHALL be registered and aligned with the digit outputs.
- REQ-027 Pause held high while in IDLE SHALL have no effect; Start with Pause=1 SHALL enter RUNNING and then PAUSED on the next edge.

Reset
- REQ-028 Reset SHALL force on the next edge: State=IDLE, both digits=0, TimeUp=0, Warning=0.
- REQ-029 Reset SHALL override all other inputs, including mid-countdown and coincident Start.

Structure
- REQ-030 A shared package game_pkg SHALL hold the state encoding constants, BCD_MAX=9, and the digit width of 4.
- REQ-031 One sub-module, bcd_down_digit, SHALL be used: load, decrement-enable, borrow-out, and zero flag; instantiated twice (ones borrow chained into tens).

Verification
- REQ-032 The bench SHALL cover: Start with 30 plus ticks -> 29 after the first tick, 20 after 10 ticks, 00 after 30 ticks, TimeUp exactly one pulse, State=EXPIRED.
- REQ-033 The bench SHALL cover: start 12, Tick and Pause in the same cycle -> remains 12 and enters PAUSED; 5 further ticks -> still 12; Pause=0, then 1 tick -> 11.
- REQ-034 The bench SHALL cover: start 15, WARN_SECONDS=10 -> Warning 0 through 11 and 1 from 10 down to 01; Warning 0 in EXPIRED.
- REQ-035 The bench SHALL cover: Start with digits F and 7 -> loads 97; Start with 00 -> EXPIRED, TimeUp one pulse, no further decrement.
- REQ-036 The bench SHALL cover: mid-count at 08, Abort and Start asserted together -> IDLE with 00; Reset at 05 -> IDLE with 00 and TimeUp never asserted.
